// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, fetches over a req/ack handshake and
// buffers {instruction, PC+4} in a small FIFO feeding the IF/ID register.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [31:0]              if_pc4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [31:0]   r_fpc;
  logic [31:0]   r_reqAddr;
  logic [31:0]   r_pendingPc;
  logic [31:0]   r_memInstr [DEPTH];
  logic [31:0]   r_memPc4   [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_occNext;
  logic          w_notFull;
  logic [31:0]   w_addrPlus4;

  assign w_pop       = if_valid && !stall;
  assign w_push      = (r_state == REQ) && imem_ack && !redirect;
  // At most one request is ever outstanding, so count + push never exceeds DEPTH.
  assign w_occNext   = r_count + CW'(w_push) - CW'(w_pop);
  assign w_notFull   = (w_occNext != FULL_CNT);
  assign w_addrPlus4 = r_reqAddr + 32'd4;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (!redirect && w_notFull) w_stateNext = REQ;
      REQ: begin
        if (imem_ack)      w_stateNext = (!redirect && w_notFull) ? REQ : IDLE;
        else if (redirect) w_stateNext = DISCARD;
      end
      DISCARD: if (imem_ack) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == REQ) || (r_state == DISCARD);
  end

  assign imem_addr = r_reqAddr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fpc       <= RESET_PC;
      r_reqAddr   <= RESET_PC;
      r_pendingPc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect)                r_fpc     <= redirect_pc;
          else if (w_stateNext == REQ) r_reqAddr <= r_fpc;
        end
        REQ: begin
          if (imem_ack && redirect) begin
            r_fpc <= redirect_pc;
          end else if (imem_ack) begin
            r_fpc     <= w_addrPlus4;
            r_reqAddr <= w_addrPlus4;
          end else if (redirect) begin
            r_pendingPc <= redirect_pc;
          end
        end
        DISCARD: begin
          // A redirect arriving with the dropped ack is the newest target.
          if (imem_ack)      r_fpc       <= redirect ? redirect_pc : r_pendingPc;
          else if (redirect) r_pendingPc <= redirect_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_memInstr[r_wrPtr] <= imem_data;
      r_memPc4[r_wrPtr]   <= w_addrPlus4;
    end
  end

  // Redirect flushes the queue and outranks push, pop and stall.
  always_ff @(posedge CLK) begin
    if (RST || redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= w_occNext;
    end
  end

  assign occupancy = r_count;
  assign if_valid  = (r_count != '0);
  assign if_instr  = if_valid ? r_memInstr[r_rdPtr] : 32'h0;
  assign if_pc4    = if_valid ? r_memPc4[r_rdPtr]   : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a configurable-latency memory responder plus a
// transaction-level reference model (queue of fetched words, fetch PC, outstanding request).
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST, imem_req, imem_ack, redirect, stall, if_valid;
  logic [31:0]   imem_addr, imem_data, redirect_pc, if_instr, if_pc4;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc4(if_pc4), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Memory contents derived from the address so every word is distinguishable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Memory responder state
  int memWait  = 0;
  int age      = 0;
  bit randWait = 0;
  bit lastAck  = 0;

  // Reference model: queue of delivered words plus fetch bookkeeping
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } entry_t;
  entry_t      mQ[$];
  logic [31:0] mFpc = RESET_PC, mAddr = RESET_PC, mPending = RESET_PC;
  bit          mOut = 0, mDrop = 0;

  logic          expReq, expValid;
  logic [31:0]   expAddr, expInstr, expPc4;
  logic [CW-1:0] expOcc;

  task automatic modelStep(input bit rst, input bit st, input bit rd,
                           input logic [31:0] rpc, input bit ackIn);
    bit ack, push, pop, wasOut;
    int newSize;
    if (rst) begin
      mQ.delete();
      mFpc = RESET_PC; mAddr = RESET_PC; mPending = RESET_PC;
      mOut = 0; mDrop = 0;
    end else begin
      ack    = mOut && ackIn;
      wasOut = mOut;
      if (rd) begin
        mQ.delete();
        if (mOut && !ack) begin
          mDrop = 1; mPending = rpc;
        end else begin
          mFpc = rpc; mOut = 0; mDrop = 0;
        end
      end else begin
        pop  = (mQ.size() > 0) && !st;
        push = ack && !mDrop;
        if (ack && mDrop) mFpc = mPending;
        if (push) mFpc = mAddr + 32'd4;
        newSize = mQ.size() + int'(push) - int'(pop);
        if (pop) void'(mQ.pop_front());
        if (push) mQ.push_back('{memWord(mAddr), mAddr + 32'd4});
        if (ack) mOut = 0;
        // New fetch from idle, or back-to-back after a delivered word, if room remains
        if (newSize < DEPTH && (!wasOut || push)) begin
          mOut = 1; mAddr = mFpc;
        end
        if (ack) mDrop = 0;
      end
    end
    expReq   = mOut;
    expAddr  = mOut ? mAddr : 32'h0;
    expOcc   = CW'(mQ.size());
    expValid = (mQ.size() > 0);
    expInstr = expValid ? mQ[0].instr : 32'h0;
    expPc4   = expValid ? mQ[0].pc4   : 32'h0;
  endtask

  // One clock: drive inputs, respond as memory, advance the model, sample after the edge.
  task automatic applyStimulus(input bit rst, input bit st, input bit rd,
                               input logic [31:0] rpc);
    bit reqBefore;
    RST = rst; stall = st; redirect = rd; redirect_pc = rpc;
    reqBefore = (imem_req === 1'b1);
    imem_ack  = reqBefore && (age >= memWait);
    imem_data = memWord(imem_addr);
    lastAck   = imem_ack;
    modelStep(rst, st, rd, rpc, imem_ack);
    @(posedge CLK); #1;
    if (rst || lastAck) begin
      age = 0;
      if (randWait) memWait = $urandom_range(0, 3);
    end else if (reqBefore) begin
      age++;
    end
  endtask

  task automatic test_reset();
    memWait = 0; randWait = 0;
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    checks++;
    if ({imem_req, occupancy, if_valid} !== {1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: req=%b occ=%0d valid=%b, want 0 0 0", imem_req, occupancy, if_valid);
    end
    checks++;
    if ({if_instr, if_pc4, imem_addr} !== {32'h0, 32'h0, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL reset_data: instr=%h pc4=%h addr=%h, want 0 0 %h", if_instr, if_pc4, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    memWait = 0;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(0, 0, 0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c - 1))) begin
        errors++;
        $display("[TB] FAIL zw_addr cyc %0d: req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, 32'(4 * (c - 1)));
      end
      if (c >= 2) begin
        checks++;
        if (if_valid !== 1'b1 || if_instr !== memWord(32'(4 * (c - 2))) || if_pc4 !== 32'(4 * (c - 1))) begin
          errors++;
          $display("[TB] FAIL zw_out cyc %0d: v=%b instr=%h pc4=%h, want 1 %h %h", c, if_valid, if_instr, if_pc4,
                   memWord(32'(4 * (c - 2))), 32'(4 * (c - 1)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] holdInstr, holdPc4;
    holdInstr = expInstr;
    holdPc4   = expPc4;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checks++;
      if (if_instr !== holdInstr || if_pc4 !== holdPc4 || occupancy !== expOcc || imem_req !== expReq) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc %0d: instr=%h pc4=%h occ=%0d req=%b, want %h %h %0d %b", c, if_instr,
                 if_pc4, occupancy, imem_req, holdInstr, holdPc4, expOcc, expReq);
      end
    end
    checks++;
    if (occupancy !== CW'(DEPTH) || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_full: occ=%0d req=%b, want %0d 0", occupancy, imem_req, DEPTH);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc4 !== holdPc4 + 32'(4 * k) || if_instr !== memWord(holdPc4 + 32'(4 * k) - 32'd4)) begin
        errors++;
        $display("[TB] FAIL stall_drain k %0d: v=%b pc4=%h instr=%h, want 1 %h %h", k, if_valid, if_pc4, if_instr,
                 holdPc4 + 32'(4 * k), memWord(holdPc4 + 32'(4 * k) - 32'd4));
      end
    end
  endtask

  task automatic test_wait_states();
    logic        prevReq;
    logic [31:0] prevAddr;
    bit          prevAck;
    memWait = 3;
    applyStimulus(1, 0, 0, 32'h0);
    prevReq = 1'b0; prevAddr = 32'h0; prevAck = 0;
    for (int c = 1; c <= 24; c++) begin
      applyStimulus(0, 0, 0, 32'h0);
      checks++;
      if ({imem_req, occupancy, if_valid, if_instr, if_pc4} !== {expReq, expOcc, expValid, expInstr, expPc4}
          || occupancy > CW'(1) || (imem_req && prevReq && !lastAck && imem_addr !== prevAddr)) begin
        errors++;
        $display("[TB] FAIL ws cyc %0d: req=%b addr=%h occ=%0d v=%b pc4=%h, want %b %h %0d %b %h", c, imem_req,
                 imem_addr, occupancy, if_valid, if_pc4, expReq, expAddr, expOcc, expValid, expPc4);
      end
      prevReq = imem_req; prevAddr = imem_addr; prevAck = lastAck;
    end
  endtask

  task automatic test_redirect_discard();
    bit found, sawTarget;
    memWait = 3;
    applyStimulus(1, 0, 0, 32'h0);
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      applyStimulus(0, 0, 0, 32'h0);
      if (mOut && mAddr == 32'h10 && age == 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL rd_setup: request to 0x10 never seen waiting, got addr=%h want 00000010", imem_addr);
    end
    applyStimulus(0, 0, 1, 32'h100);
    checks++;
    if ({imem_req, imem_addr, occupancy, if_valid} !== {1'b1, 32'h10, CW'(0), 1'b0}) begin
      errors++;
      $display("[TB] FAIL rd_discard: req=%b addr=%h occ=%0d v=%b, want 1 00000010 0 0", imem_req, imem_addr,
               occupancy, if_valid);
    end
    sawTarget = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus(0, 0, 0, 32'h0);
      if (imem_req === 1'b1 && imem_addr === 32'h100) sawTarget = 1;
      checks++;
      if ({imem_req, expAddr, occupancy, if_valid, if_pc4} !== {expReq, (imem_req ? imem_addr : 32'h0), expOcc, expValid, expPc4}
          || if_pc4 === 32'h14) begin
        errors++;
        $display("[TB] FAIL rd_model cyc %0d: req=%b addr=%h occ=%0d pc4=%h, want %b %h %0d %h", c, imem_req,
                 imem_addr, occupancy, if_pc4, expReq, expAddr, expOcc, expPc4);
      end
      if (if_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || !sawTarget || if_pc4 !== 32'h104) begin
      errors++;
      $display("[TB] FAIL rd_first: pc4=%h sawTarget=%0d, want 00000104 1", if_pc4, sawTarget);
    end
  endtask

  task automatic test_redirect_ack_same();
    memWait = 0;
    applyStimulus(1, 0, 0, 32'h0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'h200);
    checks++;
    if ({imem_req, occupancy, if_valid} !== {1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("[TB] FAIL rack_flush: req=%b occ=%0d v=%b, want 0 0 0", imem_req, occupancy, if_valid);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL rack_restart: req=%b addr=%h, want 1 00000200", imem_req, imem_addr);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc4 !== 32'h204 || if_instr !== memWord(32'h200)) begin
      errors++;
      $display("[TB] FAIL rack_first: v=%b pc4=%h instr=%h, want 1 00000204 %h", if_valid, if_pc4, if_instr,
               memWord(32'h200));
    end
    for (int c = 0; c < 8; c++) applyStimulus(0, 1, 0, 32'h0);
    checks++;
    if (occupancy !== CW'(DEPTH) || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rfull_fill: occ=%0d req=%b, want %0d 0", occupancy, imem_req, DEPTH);
    end
    applyStimulus(0, 1, 1, 32'h300);
    checks++;
    if ({occupancy, if_valid, if_instr, if_pc4} !== {CW'(0), 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rfull_flush: occ=%0d v=%b instr=%h pc4=%h, want 0 0 0 0", occupancy, if_valid, if_instr, if_pc4);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("[TB] FAIL rfull_restart: req=%b addr=%h, want 1 00000300", imem_req, imem_addr);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc4 !== 32'h304) begin
      errors++;
      $display("[TB] FAIL rfull_first: v=%b pc4=%h, want 1 00000304", if_valid, if_pc4);
    end
  endtask

  task automatic test_reset_mid();
    memWait = 0;
    applyStimulus(1, 0, 0, 32'h0);
    for (int c = 0; c < 4; c++) applyStimulus(0, 1, 0, 32'h0);
    checks++;
    if (occupancy !== CW'(3) || imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_setup: occ=%0d req=%b, want 3 1", occupancy, imem_req);
    end
    applyStimulus(1, 1, 0, 32'h0);
    checks++;
    if ({imem_req, occupancy, if_valid} !== {1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("[TB] FAIL rmid_reset: req=%b occ=%0d v=%b, want 0 0 0", imem_req, occupancy, if_valid);
    end
    applyStimulus(0, 0, 0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL rmid_refetch: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          st, rd, rs;
    logic [31:0] rpc;
    randWait = 1;
    memWait  = $urandom_range(0, 3);
    applyStimulus(1, 0, 0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 5);
      rs  = ($urandom_range(0, 199) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus(rs, st, rd, rpc);
      checks++;
      if ({imem_req, (imem_req ? imem_addr : 32'h0), occupancy, if_valid, if_instr, if_pc4}
          !== {expReq, expAddr, expOcc, expValid, expInstr, expPc4}) begin
        errors++;
        $display("[TB] FAIL rand cyc %0d: req=%b addr=%h occ=%0d v=%b instr=%h pc4=%h, want %b %h %0d %b %h %h", c,
                 imem_req, imem_addr, occupancy, if_valid, if_instr, if_pc4, expReq, expAddr, expOcc, expValid,
                 expInstr, expPc4);
      end
    end
    randWait = 0;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_data = 32'h0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_wait_states();
    test_redirect_discard();
    test_redirect_ack_same();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the pipeline's IF/ID register. It owns the fetch PC, fetches from a variable-latency instruction memory over a req/ack handshake, and buffers fetched words with their PC+4 in a small FIFO. It presents one instruction per cycle to IF/ID, holds it under stall, and flushes on a taken-branch redirect from the MEM stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; stable while imem_req high
- imem_ack  input  1  memory completes request this cycle; sampled only while imem_req high
- imem_data  input  32  instruction word, valid with imem_ack
- redirect  input  1  taken branch (Branch && Zero from EX/MEM)
- redirect_pc  input  32  branch target, valid with redirect
- stall  input  1  hold current output (hazard stall of IF/ID)
- if_valid  output  1  if_instr/if_pc4 hold a real instruction
- if_instr  output  32  FIFO head instruction; 32'h0 (NOP) when !if_valid
- if_pc4  output  32  PC+4 of head instruction; 32'h0 when !if_valid
- occupancy  output  $clog2(DEPTH)+1  FIFO entry count

## Operation
- States: IDLE (no request), REQ (imem_req=1, waiting ack), DISCARD (imem_req=1, waiting ack whose data is dropped).
- imem_req = (state==REQ || state==DISCARD); imem_addr = registered req_addr.
- Pop = if_valid && !stall. Push = ack in REQ && !redirect. occupancy_next = occupancy + push − pop (push and pop together: unchanged).
- Push writes {imem_data, req_addr+4}; FIFO pointers wrap modulo DEPTH.
- IDLE: if !redirect and occupancy_next < DEPTH → REQ with req_addr = fpc. If redirect → fpc = redirect_pc, stay IDLE.
- REQ, ack, no redirect: fpc = req_addr+4; if occupancy_next < DEPTH stay REQ with req_addr = req_addr+4 (back-to-back fetch), else IDLE.
- REQ, no ack, redirect: → DISCARD; pending_pc = redirect_pc; req_addr unchanged (request never withdrawn).
- REQ, ack and redirect same cycle: handshake complete, data dropped, fpc = redirect_pc, → IDLE.
- DISCARD, ack: data dropped, fpc = pending_pc, → IDLE. DISCARD, new redirect without ack: pending_pc overwritten (latest redirect wins).
- Redirect (any state) flushes the FIFO at the same edge: occupancy = 0, pointers = 0; redirect has priority over push, pop and stall.
- Full: no request issued while occupancy_next == DEPTH; at most one request outstanding, so FIFO never overflows.
- Address arithmetic is 32-bit unsigned, wraps 32'hFFFF_FFFC → 32'h0000_0000. Low two bits of addresses passed through unchecked.

## Timing
- RST sampled high: state=IDLE, fpc=req_addr=pending_pc=RESET_PC, occupancy=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0. RST overrides every other input; RST during REQ/DISCARD drops imem_req next cycle (memory shares RST).
- First imem_req: cycle 1 after RST deasserts (IDLE→REQ edge).
- Zero-wait memory (ack same cycle as req): data visible on if_instr one cycle after ack; steady throughput one instruction/cycle.
- N-wait memory: one instruction per N+1 cycles.
- Redirect at edge t: if_valid=0 from t+1; first target request at t+1 if no request was outstanding, otherwise one cycle after the DISCARD ack.
- Outputs if_valid/if_instr/if_pc4 are combinational from FIFO head registers; stall does not change them.

## Test plan
- Reset, zero-wait memory returning addr-based word: imem_addr 0,4,8,… on consecutive cycles from cycle 1; if_instr for addr 0 appears cycle 2 with if_pc4=4; one instruction per cycle.
- Hold stall=1 for 10 cycles with zero-wait memory: occupancy rises to 4, imem_req drops, if_instr unchanged; release → entries drain in order, requests resume, no loss or duplication.
- Memory with 3 wait states: imem_addr stable across wait cycles; one push per 4 cycles; occupancy never exceeds 1 with stall=0.
- Redirect to 32'h0000_0100 while request to 0x10 is waiting: DISCARD, 0x10 data never appears, FIFO empty next cycle, next imem_addr = 0x100 after ack; first output if_pc4 = 0x104.
- Redirect and ack same cycle, and redirect with FIFO full plus stall=1: data dropped, occupancy=0 next cycle, if_valid=0, fetch restarts at redirect_pc.
- RST asserted mid-REQ with 3 entries buffered: next cycle imem_req=0, occupancy=0, if_valid=0; refetch from RESET_PC.
